instr_encoder: RTL and testbench

Pipelined RV32 instruction encoder. It is the inverse of the datapath's immediate generator: it takes decoded fields (format, registers, funct3, signed immediate) and packs them into a 32-bit instruction word in the standard RV32I layout. Each emitted word carries a sequential instruction-memory address. It sits on the program-loader path and feeds the instruction-memory write port through a valid/ready handshake.

---
 rtl/instr_encoder_pkg.sv | 33 +++
 rtl/instr_encoder_field_pack.sv | 61 ++++++
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared opcodes, format enum, field positions and immediate range rule
package instr_encoder_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_B = 2'd2,
        FMT_J = 2'd3
    } fmt_e;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    // Branch and jump offsets are halfword-granular, so an odd offset cannot be encoded
    function automatic logic imm_in_range(fmt_e fmt, logic [31:0] imm);
        logic signed [31:0] v;
        v = imm;
        imm_in_range = (fmt == FMT_I || fmt == FMT_S) ? (v >= -32'sd2048 && v <= 32'sd2047) :
                       (fmt == FMT_B) ? (v >= -32'sd4096 && v <= 32'sd4094 && !imm[0]) :
                       (v >= -32'sd1048576 && v <= 32'sd1048574 && !imm[0]);
    endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack: combinational packing of decoded fields into an RV32I word plus range check
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_ok
);

    fmt_e f;

    assign f = fmt_e'(fmt);

    // Scatter the immediate into each format's bit layout; unused fields stay zero
    always_comb begin
        instr = ZERO;
        case (f)
            FMT_I: begin
                instr[OPC_LSB +: 7] = OPC_LOAD;
                instr[RD_LSB +: 5]  = rd;
                instr[F3_LSB +: 3]  = funct3;
                instr[RS1_LSB +: 5] = rs1;
                instr[31:20]        = imm[11:0];
            end
            FMT_S: begin
                instr[OPC_LSB +: 7] = OPC_STORE;
                instr[RD_LSB +: 5]  = imm[4:0];
                instr[F3_LSB +: 3]  = funct3;
                instr[RS1_LSB +: 5] = rs1;
                instr[RS2_LSB +: 5] = rs2;
                instr[31:25]        = imm[11:5];
            end
            FMT_B: begin
                instr[OPC_LSB +: 7] = OPC_BRANCH;
                instr[7]            = imm[11];
                instr[11:8]         = imm[4:1];
                instr[F3_LSB +: 3]  = funct3;
                instr[RS1_LSB +: 5] = rs1;
                instr[RS2_LSB +: 5] = rs2;
                instr[30:25]        = imm[10:5];
                instr[31]           = imm[12];
            end
            default: begin
                instr[OPC_LSB +: 7] = OPC_JAL;
                instr[RD_LSB +: 5]  = rd;
                instr[19:12]        = imm[19:12];
                instr[20]           = imm[11];
                instr[30:21]        = imm[10:1];
                instr[31]           = imm[20];
            end
        endcase
    end

    assign range_ok = imm_in_range(f, imm);

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32 instruction encoder with sequential addressing and valid/ready flow
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    output logic             oReady,
    input  logic [1:0]       iFmt,
    input  logic [4:0]       iRd,
    input  logic [4:0]       iRs1,
    input  logic [4:0]       iRs2,
    input  logic [2:0]       iFunct3,
    input  logic [31:0]      iImm,
    input  logic             iFlush,
    output logic             oValid,
    input  logic             iReady,
    output logic [31:0]      oInstr,
    output logic [31:0]      oAddr,
    output logic             oErr,
    output logic [CNT_W-1:0] oCount
);

    logic        s1_valid;
    logic [1:0]  s1_fmt;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic [31:0] s1_imm;
    logic [31:0] pk_instr;
    logic        pk_ok;
    logic [31:0] addr;
    logic [31:0] next_addr;
    logic        s2_adv;
    logic        s1_adv;
    logic        accept;
    logic        out_hs;

    assign s2_adv    = !oValid || iReady;
    assign s1_adv    = !s1_valid || s2_adv;
    assign oReady    = s1_adv && !iFlush && iRST;
    assign accept    = iValid && oReady;
    assign out_hs    = oValid && iReady;
    // A word entering stage 2 takes the slot after any word leaving in the same cycle
    assign next_addr = out_hs ? addr + 32'd4 : addr;

    // Stage 1 occupancy; flush and reset discard whatever is held
    always_ff @(posedge iCLK) begin
        if (!iRST || iFlush)
            s1_valid <= 1'b0;
        else if (s1_adv)
            s1_valid <= accept;
    end

    // Stage 1 raw field capture, only on an accepted input
    always_ff @(posedge iCLK) begin
        if (accept) begin
            s1_fmt <= iFmt;
            s1_rd  <= iRd;
            s1_rs1 <= iRs1;
            s1_rs2 <= iRs2;
            s1_f3  <= iFunct3;
            s1_imm <= iImm;
        end
    end

    instr_field_pack u_pack (
        .fmt      (s1_fmt),
        .rd       (s1_rd),
        .rs1      (s1_rs1),
        .rs2      (s1_rs2),
        .funct3   (s1_f3),
        .imm      (s1_imm),
        .instr    (pk_instr),
        .range_ok (pk_ok)
    );

    // Stage 2 output register; out-of-range entries pass through as a bubble
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            oValid <= 1'b0;
            oInstr <= ZERO;
            oAddr  <= BASE_ADDR;
        end else if (iFlush) begin
            oValid <= 1'b0;
            oAddr  <= BASE_ADDR;
        end else if (s2_adv) begin
            oValid <= s1_valid && pk_ok;
            if (s1_valid && pk_ok) begin
                oInstr <= pk_instr;
                oAddr  <= next_addr;
            end
        end
    end

    // Next-address, emitted-count and sticky range-error bookkeeping
    always_ff @(posedge iCLK) begin
        if (!iRST || iFlush) begin
            addr   <= BASE_ADDR;
            oCount <= '0;
            oErr   <= 1'b0;
        end else begin
            if (out_hs) begin
                addr   <= addr + 32'd4;
                oCount <= oCount + CNT_W'(1);
            end
            if (s1_valid && s2_adv && !pk_ok)
                oErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iValid;
    logic        oReady;
    logic [1:0]  iFmt;
    logic [4:0]  iRd;
    logic [4:0]  iRs1;
    logic [4:0]  iRs2;
    logic [2:0]  iFunct3;
    logic [31:0] iImm;
    logic        iFlush;
    logic        oValid;
    logic        iReady;
    logic [31:0] oInstr;
    logic [31:0] oAddr;
    logic        oErr;
    logic [15:0] oCount;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    int          exp_cnt;
    logic        err_exp;
    logic [31:0] q[$];

    always #5 iCLK = ~iCLK;

    instr_encoder #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady),
        .iFmt(iFmt), .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iFunct3(iFunct3), .iImm(iImm),
        .iFlush(iFlush), .oValid(oValid), .iReady(iReady), .oInstr(oInstr),
        .oAddr(oAddr), .oErr(oErr), .oCount(oCount)
    );

    // Reference encoding from the RV32I field table: returns {range_ok, word}
    function automatic logic [32:0] model(int fmt, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [2:0] f3, logic [31:0] imm);
        int          v;
        logic        ok;
        logic [31:0] w;
        logic [31:0] base;
        v    = imm;
        base = (32'(rs1) << 15) | (32'(f3) << 12);
        case (fmt)
            0: begin
                ok = v >= -2048 && v <= 2047;
                w  = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'h03;
            end
            1: begin
                ok = v >= -2048 && v <= 2047;
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7) | 32'h23;
            end
            2: begin
                ok = v >= -4096 && v <= 4094 && imm[0] == 1'b0;
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base |
                     (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            end
            default: begin
                ok = v >= -1048576 && v <= 1048574 && imm[0] == 1'b0;
                w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
                     (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
            end
        endcase
        return {ok, w};
    endfunction

    function automatic logic [31:0] rand_imm(int fmt);
        int lim;
        int v;
        lim = fmt < 2 ? 2048 : (fmt == 2 ? 4096 : (1 << 20));
        v   = int'($urandom_range(2 * lim - 1)) - lim;
        if (fmt >= 2) v = v & ~1;
        if ($urandom_range(11) == 0) v = ($urandom_range(1) != 0) ? lim + int'($urandom_range(64)) : (v | 1);
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(int fmt, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3, logic [31:0] imm);
        iFmt = 2'(fmt); iRd = rd; iRs1 = rs1; iRs2 = rs2; iFunct3 = f3; iImm = imm;
    endtask

    task automatic drive(string tag, int fmt, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic [2:0] f3, logic [31:0] imm);
        put(fmt, rd, rs1, rs2, f3, imm);
        iValid = 1'b1;
        #1;
        chk(tag, oReady, 1);
        @(negedge iCLK);
        iValid = 1'b0;
    endtask

    task automatic expect_word(string tag, logic [31:0] instr);
        int n;
        n = 0;
        while (!oValid && n < 10) begin
            @(negedge iCLK);
            n++;
        end
        chk({tag, "_valid"}, oValid, 1);
        chk({tag, "_instr"}, oInstr, instr);
        chk({tag, "_addr"}, oAddr, exp_addr);
        @(negedge iCLK);
        exp_addr += 4;
        exp_cnt++;
        chk({tag, "_cnt"}, oCount, 32'(exp_cnt));
    endtask

    initial begin
        logic        saw;
        int          k;
        logic [31:0] w;
        logic [32:0] r;
        logic [31:0] bp_imm[3];
        logic [31:0] bp_w[3];

        iRST = 1'b0; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b1;
        put(0, 0, 0, 0, 0, 0);
        exp_addr = BASE; exp_cnt = 0; err_exp = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        chk("rst_valid", oValid, 0);
        chk("rst_instr", oInstr, 0);
        chk("rst_addr", oAddr, BASE);
        chk("rst_err", oErr, 0);
        chk("rst_cnt", oCount, 0);
        chk("rst_ready", oReady, 0);
        iRST = 1'b1;
        @(negedge iCLK);

        drive("i_rdy", 0, 5, 2, 0, 2, -32'sd4);
        chk("i_lat1", oValid, 0);
        @(negedge iCLK);
        chk("i_lat2", oValid, 1);
        expect_word("i", 32'hFFC12283);

        drive("s_rdy", 1, 0, 2, 3, 2, 32'd8);
        drive("b_rdy", 2, 0, 1, 2, 0, -32'sd8);
        expect_word("s", 32'h00312423);
        chk("sb_b2b", oValid, 1);
        expect_word("b", 32'hFE208CE3);

        drive("j_rdy", 3, 1, 0, 0, 0, 32'd2048);
        expect_word("j", 32'h001000EF);
        drive("jbad_rdy", 3, 1, 0, 0, 0, 32'h0010_0000);
        saw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            saw |= oValid;
            @(negedge iCLK);
        end
        chk("jbad_drop", saw, 0);
        chk("jbad_err", oErr, 1);
        chk("jbad_cnt", oCount, 32'(exp_cnt));
        drive("after_rdy", 0, 7, 9, 0, 3, 32'd100);
        expect_word("after", model(0, 7, 9, 0, 3, 32'd100));

        bp_imm[0] = 32'd16; bp_imm[1] = -32'sd32; bp_imm[2] = 32'd2047;
        for (int i = 0; i < 3; i++) bp_w[i] = model(0, 5'(10 + i), 5'd1, 5'd0, 3'd2, bp_imm[i]);
        iReady = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            put(0, 5'(10 + k), 1, 0, 2, bp_imm[k]);
            iValid = 1'b1;
            #1;
            if (c >= 3) begin
                chk("bp_ready", oReady, 0);
                chk("bp_stable", oInstr, bp_w[0]);
                chk("bp_addr", oAddr, exp_addr);
            end
            if (oReady && k < 2) k++;
            @(negedge iCLK);
        end
        chk("bp_acc", k, 2);
        iReady = 1'b1;
        #1;
        chk("bp_resume_rdy", oReady, 1);
        chk("bp_w0", oInstr, bp_w[0]);
        chk("bp_a0", oAddr, exp_addr);
        @(negedge iCLK);
        iValid = 1'b0;
        exp_addr += 4;
        exp_cnt++;
        expect_word("bp_w1", bp_w[1]);
        expect_word("bp_w2", bp_w[2]);

        iReady = 1'b0;
        drive("fl_rdy0", 0, 1, 1, 0, 0, 32'd1);
        drive("fl_rdy1", 0, 2, 2, 0, 0, 32'd2);
        iFlush = 1'b1; iValid = 1'b1; iReady = 1'b1;
        #1;
        chk("fl_ready", oReady, 0);
        @(negedge iCLK);
        iFlush = 1'b0; iValid = 1'b0;
        chk("fl_valid", oValid, 0);
        chk("fl_cnt", oCount, 0);
        chk("fl_err", oErr, 0);
        exp_addr = BASE; exp_cnt = 0;
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            saw |= oValid;
            @(negedge iCLK);
        end
        chk("fl_nostale", saw, 0);
        drive("fl_next_rdy", 0, 3, 4, 0, 1, -32'sd2048);
        expect_word("fl_next", model(0, 3, 4, 0, 1, -32'sd2048));

        drive("mr_rdy0", 1, 0, 5, 6, 2, 32'd12);
        drive("mr_rdy1", 1, 0, 6, 7, 2, 32'd20);
        iRST = 1'b0;
        @(negedge iCLK);
        chk("mr_valid", oValid, 0);
        chk("mr_instr", oInstr, 0);
        chk("mr_addr", oAddr, BASE);
        chk("mr_cnt", oCount, 0);
        chk("mr_ready", oReady, 0);
        iRST = 1'b1;
        exp_addr = BASE; exp_cnt = 0;
        saw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            saw |= oValid;
            @(negedge iCLK);
        end
        chk("mr_nostale", saw, 0);

        for (int c = 0; c < 600; c++) begin
            chk("rnd_cnt", oCount, 32'(exp_cnt[15:0]));
            iReady = (c >= 590) || ($urandom_range(3) != 0);
            iValid = (c < 590) && ($urandom_range(9) < 7);
            put(int'($urandom_range(3)), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 32'd0);
            iImm = rand_imm(int'(iFmt));
            #1;
            if (oValid && iReady) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", oValid, 0);
                end else begin
                    w = q.pop_front();
                    chk("rnd_instr", oInstr, w);
                    chk("rnd_addr", oAddr, exp_addr);
                    exp_addr += 4;
                    exp_cnt++;
                end
            end
            if (iValid && oReady) begin
                r = model(int'(iFmt), iRd, iRs1, iRs2, iFunct3, iImm);
                if (r[32]) q.push_back(r[31:0]);
                else err_exp = 1'b1;
            end
            @(negedge iCLK);
        end
        iValid = 1'b0;
        chk("rnd_drained", q.size(), 0);
        chk("rnd_err", oErr, err_exp);
        chk("rnd_final_cnt", oCount, 32'(exp_cnt[15:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
